line_follow_ctrl: RTL and testbench

//  Closed-loop steering controller fed by the frame-level centroid tracker (centroid_x/line_valid/line_lost).
//  Per frame: computes lateral error vs image centre, applies P(+D) correction, sequences TRACK/HOLD/SEARCH

---
 rtl/line_follow_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_follow_ctrl.sv
// Line-follow steering: frame error -> P(+D, when LINE_FOLLOW_DERIV_EN is defined) duties, TRACK/HOLD/SEARCH recovery, two PWMs.
// Duties and cmd_valid register two cycles after line_valid; no back-pressure, every accepted frame is processed in order.
module line_follow_ctrl #(
    parameter int IMG_W            = 640,
    parameter int DUTY_W           = 8,
    parameter int BASE_DUTY        = 128,
    parameter int KP_SHIFT         = 2,
    parameter int KD_SHIFT         = 1,
    parameter int LOST_HOLD_FRAMES = 4,
    parameter int SEARCH_DUTY      = 64,
    parameter int PWM_PRESC        = 16,
    localparam int X_W             = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [X_W-1:0]    centroid_x,
    input  logic              line_valid,
    input  logic              line_lost,
    output logic [DUTY_W-1:0] duty_l,
    output logic [DUTY_W-1:0] duty_r,
    output logic              cmd_valid,
    output logic              pwm_l,
    output logic              pwm_r,
    output logic [1:0]        state_o,
    output logic              search_dir
);
    localparam int DMAX  = 2**DUTY_W - 1;
    localparam int E_W   = X_W + 1;
    localparam int C_W   = DUTY_W + X_W + 2;
    localparam int CNT_W = $clog2(LOST_HOLD_FRAMES + 1);
    localparam int PR_W  = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;

    localparam logic signed [E_W-1:0] CENTRE = E_W'(IMG_W / 2);
    localparam logic signed [C_W-1:0] BASE_S = C_W'(BASE_DUTY);
    localparam logic signed [C_W-1:0] DMAX_S = C_W'(DMAX);
    localparam logic [DUTY_W-1:0]     SPIN   = DUTY_W'(SEARCH_DUTY);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_HOLD   = 2'd2,
        S_SEARCH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  ev_vld_q, ev_lost_q;
    logic signed [E_W-1:0] err_q, err_in;
    logic [DUTY_W-1:0]     duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic                  cmd_q, cmd_d, dir_q, dir_d;
    logic [CNT_W-1:0]      lost_cnt_q, lost_cnt_d;
    logic                  trk_upd, spin;
    logic [PR_W-1:0]       presc_q, presc_d;
    logic [DUTY_W-1:0]     pwm_cnt_q, pwm_cnt_d, shad_l_q, shad_l_d, shad_r_q, shad_r_d;
    logic                  pwm_l_q, pwm_r_q, tick;
    logic signed [C_W-1:0] err_ext, p_term, corr_trk, corr, sum_l, sum_r;

    assign err_in  = $signed({1'b0, centroid_x}) - CENTRE;
    assign err_ext = {{(C_W-E_W){err_q[E_W-1]}}, err_q};
    assign p_term  = err_ext >>> KP_SHIFT;

`ifdef LINE_FOLLOW_DERIV_EN
    logic signed [E_W-1:0] err_prev_q;
    logic signed [C_W-1:0] prev_ext, d_term;

    assign prev_ext = {{(C_W-E_W){err_prev_q[E_W-1]}}, err_prev_q};
    assign d_term   = (err_ext - prev_ext) >>> KD_SHIFT;
    assign corr_trk = p_term + d_term;

    always_ff @(posedge clk) begin
        if (rst)          err_prev_q <= '0;
        else if (trk_upd) err_prev_q <= err_q;
    end
`else
    assign corr_trk = p_term;
`endif

    // Re-entering TRACK from HOLD/SEARCH uses P only, so the first D term after a gap is zero.
    assign corr  = (state_q == S_TRACK) ? corr_trk : p_term;
    assign sum_l = BASE_S + corr;
    assign sum_r = BASE_S - corr;

    function automatic logic [DUTY_W-1:0] clamp(input logic signed [C_W-1:0] v);
        if (v < 0)           return '0;
        else if (v > DMAX_S) return DUTY_W'(DMAX);
        else                 return v[DUTY_W-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        duty_l_d   = duty_l_q;
        duty_r_d   = duty_r_q;
        cmd_d      = 1'b0;
        dir_d      = dir_q;
        lost_cnt_d = lost_cnt_q;
        trk_upd    = 1'b0;
        spin       = 1'b0;
        if (!enable) begin
            state_d    = S_IDLE;
            lost_cnt_d = '0;
            if (state_q != S_IDLE) begin
                duty_l_d = '0;
                duty_r_d = '0;
                cmd_d    = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: spin = 1'b1;
                S_TRACK: begin
                    if (ev_vld_q) begin
                        if (!ev_lost_q)                 trk_upd = 1'b1;
                        else if (LOST_HOLD_FRAMES <= 1) spin    = 1'b1;
                        else begin
                            state_d    = S_HOLD;
                            lost_cnt_d = CNT_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (ev_vld_q) begin
                        if (!ev_lost_q)                                      trk_upd    = 1'b1;
                        else if (int'(lost_cnt_q) + 1 >= LOST_HOLD_FRAMES) spin       = 1'b1;
                        else                                                 lost_cnt_d = lost_cnt_q + 1'b1;
                    end
                end
                S_SEARCH: if (ev_vld_q && !ev_lost_q) trk_upd = 1'b1;
                default: ;
            endcase
        end
        if (spin) begin
            state_d    = S_SEARCH;
            duty_l_d   = dir_q ? SPIN : '0;
            duty_r_d   = dir_q ? '0 : SPIN;
            cmd_d      = 1'b1;
            lost_cnt_d = '0;
        end
        if (trk_upd) begin
            state_d    = S_TRACK;
            duty_l_d   = clamp(sum_l);
            duty_r_d   = clamp(sum_r);
            cmd_d      = 1'b1;
            dir_d      = ~err_q[E_W-1];
            lost_cnt_d = '0;
        end
    end

    // Shadow duties only reload at the end of a PWM period so a period is never cut short.
    assign tick = (presc_q == PR_W'(PWM_PRESC - 1));
    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        shad_l_d  = shad_l_q;
        shad_r_d  = shad_r_q;
        if (tick && pwm_cnt_q == DUTY_W'(DMAX)) begin
            shad_l_d = duty_l_q;
            shad_r_d = duty_r_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ev_vld_q   <= 1'b0;
            ev_lost_q  <= 1'b0;
            err_q      <= '0;
            duty_l_q   <= '0;
            duty_r_q   <= '0;
            cmd_q      <= 1'b0;
            dir_q      <= 1'b1;
            lost_cnt_q <= '0;
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            shad_l_q   <= '0;
            shad_r_q   <= '0;
            pwm_l_q    <= 1'b0;
            pwm_r_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ev_vld_q   <= line_valid & enable;
            ev_lost_q  <= line_lost;
            if (line_valid) err_q <= err_in;
            duty_l_q   <= duty_l_d;
            duty_r_q   <= duty_r_d;
            cmd_q      <= cmd_d;
            dir_q      <= dir_d;
            lost_cnt_q <= lost_cnt_d;
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            shad_l_q   <= shad_l_d;
            shad_r_q   <= shad_r_d;
            pwm_l_q    <= (pwm_cnt_d < shad_l_d);
            pwm_r_q    <= (pwm_cnt_d < shad_r_d);
        end
    end

    assign duty_l     = duty_l_q;
    assign duty_r     = duty_r_q;
    assign cmd_valid  = cmd_q;
    assign pwm_l      = pwm_l_q;
    assign pwm_r      = pwm_r_q;
    assign state_o    = state_q;
    assign search_dir = dir_q;
endmodule

// File: tb/tb_line_follow_ctrl.sv
// Randomised bench for line_follow_ctrl: frame-level reference model compared every cycle, plus directed literal checks.
module tb_line_follow_ctrl;
    localparam int IMG_W = 640;
    localparam int X_W   = 10;
    localparam int DUTY_W = 8;
    localparam int BASE  = 128;
    localparam int KP    = 2;
    localparam int KD    = 1;
    localparam int LHF   = 4;
    localparam int SD    = 64;
    localparam int PRESC = 1;
    localparam int PER   = 256;
    localparam int DMAX  = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, enable, line_valid, line_lost;
    logic [X_W-1:0]    centroid_x;
    logic [DUTY_W-1:0] duty_l, duty_r;
    logic              cmd_valid, pwm_l, pwm_r, search_dir;
    logic [1:0]        state_o;

    line_follow_ctrl #(
        .IMG_W(IMG_W), .DUTY_W(DUTY_W), .BASE_DUTY(BASE), .KP_SHIFT(KP), .KD_SHIFT(KD),
        .LOST_HOLD_FRAMES(LHF), .SEARCH_DUTY(SD), .PWM_PRESC(PRESC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .centroid_x(centroid_x),
        .line_valid(line_valid), .line_lost(line_lost),
        .duty_l(duty_l), .duty_r(duty_r), .cmd_valid(cmd_valid),
        .pwm_l(pwm_l), .pwm_r(pwm_r), .state_o(state_o), .search_dir(search_dir)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modes 0 idle, 1 track, 2 hold, 3 search.
    int m_mode, m_dl, m_dr, m_cmd, m_dir, m_lost, m_prev, m_cyc, m_shl, m_shr, m_pwl, m_pwr;
    bit m_ok = 1'b0;
    int q_err[$];
    int q_lost[$];

    function automatic int clampd(input int v);
        return (v < 0) ? 0 : ((v > DMAX) ? DMAX : v);
    endfunction

    task automatic enter_search();
        m_mode = 3;
        m_dl   = m_dir ? SD : 0;
        m_dr   = m_dir ? 0 : SD;
        m_cmd  = 1;
        m_lost = 0;
    endtask

    task automatic track_update(input int err, input bit from_track);
        int p, d;
        p = err >>> KP;
        d = 0;
`ifdef LINE_FOLLOW_DERIV_EN
        if (from_track) d = (err - m_prev) >>> KD;
        m_prev = err;
`else
        if (from_track) d = 0;
`endif
        m_dl   = clampd(BASE + p + d);
        m_dr   = clampd(BASE - (p + d));
        m_dir  = (err >= 0) ? 1 : 0;
        m_mode = 1;
        m_lost = 0;
        m_cmd  = 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_mode = 0; m_dl = 0; m_dr = 0; m_cmd = 0; m_dir = 1; m_lost = 0; m_prev = 0;
                m_cyc = 0; m_shl = 0; m_shr = 0; m_pwl = 0; m_pwr = 0;
                q_err.delete(); q_lost.delete();
                m_ok = 1'b1;
            end else if (m_ok) begin
                int has_ev, e_err, e_lost, phase;
                has_ev = 0; e_err = 0; e_lost = 0;
                if (q_err.size() > 0) begin
                    has_ev = 1;
                    e_err  = q_err.pop_front();
                    e_lost = q_lost.pop_front();
                end
                m_cyc++;
                if ((m_cyc % PRESC) == 0 && ((m_cyc / PRESC) % PER) == 0) begin
                    m_shl = m_dl;
                    m_shr = m_dr;
                end
                phase = (m_cyc / PRESC) % PER;
                m_pwl = (phase < m_shl) ? 1 : 0;
                m_pwr = (phase < m_shr) ? 1 : 0;
                m_cmd = 0;
                if (!enable) begin
                    if (m_mode != 0) begin m_dl = 0; m_dr = 0; m_cmd = 1; end
                    m_mode = 0;
                    m_lost = 0;
                end else if (m_mode == 0) begin
                    enter_search();
                end else if (has_ev != 0) begin
                    if (e_lost == 0) track_update(e_err, m_mode == 1);
                    else if (m_mode == 1 || m_mode == 2) begin
                        m_lost++;
                        if (m_lost >= LHF) enter_search();
                        else m_mode = 2;
                    end
                end
                if (enable && line_valid) begin
                    q_err.push_back(int'(centroid_x) - IMG_W / 2);
                    q_lost.push_back(int'(line_lost));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                check("duty_l", 32'(duty_l), m_dl);
                check("duty_r", 32'(duty_r), m_dr);
                check("cmd_valid", 32'(cmd_valid), m_cmd);
                check("state_o", 32'(state_o), m_mode);
                check("search_dir", 32'(search_dir), m_dir);
                check("pwm_l", 32'(pwm_l), m_pwl);
                check("pwm_r", 32'(pwm_r), m_pwr);
            end
        end
    end

    // Returns at the negedge two cycles after line_valid was high.
    task automatic send(input int cx, input bit lost);
        @(negedge clk);
        line_valid = 1'b1;
        centroid_x = X_W'(cx);
        line_lost  = lost;
        @(negedge clk);
        line_valid = 1'b0;
        line_lost  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, hl1, hr1, hl2, hr2, lostp;
        rst = 1'b1; enable = 1'b0; line_valid = 1'b0; line_lost = 1'b0; centroid_x = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_o), 0);
        check("rst_duty_l", 32'(duty_l), 0);
        check("rst_dir", 32'(search_dir), 1);
        check("rst_pwm_l", 32'(pwm_l), 0);
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("en_state", 32'(state_o), 3);
        check("en_cmd", 32'(cmd_valid), 1);
        check("en_duty_l", 32'(duty_l), 64);
        repeat (3) @(negedge clk);

        send(400, 1'b0);
        check("t1_state", 32'(state_o), 1);
        check("t1_duty_l", 32'(duty_l), 148);
        check("t1_duty_r", 32'(duty_r), 108);
        check("t1_cmd", 32'(cmd_valid), 1);

        for (int i = 0; i < 4; i++) begin
            send(400, 1'b1);
            if (i < 3) begin
                check("t3_hold_state", 32'(state_o), 2);
                check("t3_hold_duty_l", 32'(duty_l), 148);
                check("t3_hold_duty_r", 32'(duty_r), 108);
                check("t3_hold_cmd", 32'(cmd_valid), 0);
            end else begin
                check("t3_search_state", 32'(state_o), 3);
                check("t3_search_duty_l", 32'(duty_l), 64);
                check("t3_search_duty_r", 32'(duty_r), 0);
                check("t3_search_dir", 32'(search_dir), 1);
            end
        end

        @(negedge clk);
        k = 0;
        while ((m_cyc % PER) != 0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("t4_boundary_wait", 32'(k < 600), 1);
        hl1 = 0; hr1 = 0; hl2 = 0; hr2 = 0;
        fork
            begin
                for (int i = 0; i < PER; i++) begin
                    hl1 += int'(pwm_l); hr1 += int'(pwm_r);
                    @(negedge clk);
                end
                for (int i = 0; i < PER; i++) begin
                    hl2 += int'(pwm_l); hr2 += int'(pwm_r);
                    @(negedge clk);
                end
            end
            begin
                repeat (50) @(negedge clk);
                send(250, 1'b0);
            end
        join
        check("t4_pwm_l_high_p1", 32'(hl1), 64);
        check("t4_pwm_r_high_p1", 32'(hr1), 0);
        check("t4_pwm_l_high_p2", 32'(hl2), 110);
        check("t4_pwm_r_high_p2", 32'(hr2), 146);

        line_valid = 1'b1; centroid_x = X_W'(500); enable = 1'b0;
        @(negedge clk);
        line_valid = 1'b0;
        check("t5_idle_state", 32'(state_o), 0);
        check("t5_idle_cmd", 32'(cmd_valid), 1);
        check("t5_idle_duty_l", 32'(duty_l), 0);
        @(negedge clk);
        check("t5_no_update_cmd", 32'(cmd_valid), 0);
        check("t5_no_update_duty_l", 32'(duty_l), 0);
        enable = 1'b1;
        @(negedge clk);
        check("t5_spin_dir", 32'(search_dir), 0);
        check("t5_spin_duty_r", 32'(duty_r), 64);
        k = 0;
        while (pwm_r !== 1'b1 && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("t5_pwm_high_wait", 32'(k < 600), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_pwm_r", 32'(pwm_r), 0);
        check("t5_rst_pwm_l", 32'(pwm_l), 0);
        check("t5_rst_state", 32'(state_o), 0);
        check("t5_rst_dir", 32'(search_dir), 1);
        rst = 1'b0;
        enable = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            lostp      = ((c / 500) % 2 == 1) ? 75 : 20;
            rst        = ($urandom_range(0, 499) == 0);
            enable     = ($urandom_range(0, 99) >= 3);
            line_valid = ($urandom_range(0, 2) == 0);
            line_lost  = ($urandom_range(0, 99) < lostp);
            centroid_x = X_W'($urandom_range(0, 1023));
        end
        @(negedge clk);
        rst = 1'b0; line_valid = 1'b0; line_lost = 1'b0;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
